// File: rtl/led_stretcher.sv
// Per-channel pulse stretcher that turns short event pulses into LED-visible levels.
// Define LED_STRETCHER_RETRIGGER_EN to let a new rise restart an active stretch.
module led_stretcher #(
    parameter int WIDTH       = 1,
    parameter int TICK_FACTOR = 16,
    parameter int HOLD_TICKS  = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             ena,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

`ifdef LED_STRETCHER_RETRIGGER_EN
    localparam bit RETRIGGER = 1'b1;
`else
    localparam bit RETRIGGER = 1'b0;
`endif

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_TICKS);

    logic             tick;
    logic [WIDTH-1:0] in_dly_q, in_dly_d;
    logic [WIDTH-1:0] rise;
    logic [7:0]       cnt_q [WIDTH];
    logic [7:0]       cnt_d [WIDTH];
    logic [WIDTH-1:0] out_q, out_d;
    logic             busy_q, busy_d;

    // The prescaler free-runs regardless of ena so the tick phase never drifts.
    generate
        if (TICK_FACTOR == 0) begin : g_no_presc
            assign tick = 1'b1;
        end else begin : g_presc
            logic [TICK_FACTOR-1:0] presc_q, presc_d;

            always_comb begin
                presc_d = presc_q + TICK_FACTOR'(1);
            end

            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst) begin
                    presc_q <= '0;
                end else begin
                    presc_q <= presc_d;
                end
            end

            assign tick = &presc_q;
        end
    endgenerate

    always_comb begin
        in_dly_d = in;
        rise     = in & ~in_dly_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ena) begin
                // Load wins over decrement; the zero guard keeps the counter from wrapping.
                if (rise[i] && ((cnt_q[i] == 8'd0) || RETRIGGER)) begin
                    cnt_d[i] = HOLD_LOAD;
                end else if (tick && (cnt_q[i] != 8'd0)) begin
                    cnt_d[i] = cnt_q[i] - 8'd1;
                end
            end
            out_d[i] = (cnt_d[i] != 8'd0);
        end
        busy_d = |out_d;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            in_dly_q <= '0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            in_dly_q <= in_dly_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out  = out_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_led_stretcher.sv
// Randomized and directed bench for led_stretcher, checked against a deadline-based reference model.
module tb_led_stretcher;

    localparam int WIDTH = 2;
    localparam int TF    = 2;
    localparam int P     = 4;
    localparam int HOLD  = 3;

`ifdef LED_STRETCHER_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             ena = 1'b0;
    logic [WIDTH-1:0] inSig = '0;
    logic [WIDTH-1:0] outSig;
    logic             busy;
    logic [0:0]       in2 = 1'b0;
    logic [0:0]       out2;
    logic             busy2;

    int checks   = 0;
    int failures = 0;

    // Reference model: each channel stores the enabled-tick count at which its stretch expires.
    int               edgeCount;
    int               enTicks;
    int               deadline [WIDTH];
    logic [WIDTH-1:0] prevIn;
    logic [WIDTH-1:0] expOut;

    always #5 clk = ~clk;

    led_stretcher #(.WIDTH(WIDTH), .TICK_FACTOR(TF), .HOLD_TICKS(HOLD)) dut (
        .clk(clk), .nrst(nrst), .ena(ena), .in(inSig), .out(outSig), .busy(busy)
    );

    led_stretcher #(.WIDTH(1), .TICK_FACTOR(0), .HOLD_TICKS(1)) dutFast (
        .clk(clk), .nrst(nrst), .ena(1'b1), .in(in2), .out(out2), .busy(busy2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        edgeCount = 0;
        enTicks   = 0;
        prevIn    = '0;
        expOut    = '0;
        for (int c = 0; c < WIDTH; c++) deadline[c] = 0;
    endtask

    task automatic modelStep(input logic [WIDTH-1:0] inV, input logic enaV);
        bit tickNow;
        int newTicks;
        tickNow = ((edgeCount % P) == P - 1);
        edgeCount++;
        if (enaV) begin
            newTicks = enTicks + (tickNow ? 1 : 0);
            for (int c = 0; c < WIDTH; c++) begin
                if (inV[c] && !prevIn[c] && (deadline[c] <= enTicks || RETRIG))
                    deadline[c] = newTicks + HOLD;
            end
            enTicks = newTicks;
        end
        prevIn = inV;
        for (int c = 0; c < WIDTH; c++) expOut[c] = (deadline[c] > enTicks);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic applyStimulus(input logic [WIDTH-1:0] inV, input logic enaV);
        inSig = inV;
        ena   = enaV;
        @(posedge clk);
        modelStep(inV, enaV);
        #1;
        checkOutput("out", 32'(outSig), 32'(expOut));
        checkOutput("busy", 32'(busy), 32'(|expOut));
    endtask

    task automatic doReset();
        #2;
        nrst = 1'b0;
        #1;
        checkOutput("reset_out_async", 32'(outSig), 32'd0);
        checkOutput("reset_busy_async", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        modelReset();
    endtask

    int  width0;
    int  width1;
    bit  gap;
    bit  seenHigh;
    logic [WIDTH-1:0] rv;

    initial begin
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_state_out", 32'(outSig), 32'd0);
        checkOutput("reset_state_busy", 32'(busy), 32'd0);
        nrst = 1'b1;

        // Isolated pulse on channel 0.
        applyStimulus(2'b01, 1'b1);
        checkOutput("req026_rise_next_clk", 32'(outSig[0]), 32'd1);
        width0 = 1; width1 = 0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(2'b00, 1'b1);
            if (outSig[0]) width0++;
            if (outSig[1]) width1++;
        end
        checkOutput("req026_width_in_range", 32'(width0 >= 9 && width0 <= 12), 32'd1);
        checkOutput("req026_ch1_quiet", 32'(width1), 32'd0);

        // Second pulse 6 clocks after the first.
        applyStimulus(2'b01, 1'b1);
        width0 = 1; gap = 0; seenHigh = 1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'b00, 1'b1);
            if (outSig[0]) width0++;
        end
        applyStimulus(2'b01, 1'b1);
        if (outSig[0]) width0++;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(2'b00, 1'b1);
            if (outSig[0]) begin
                if (!seenHigh) gap = 1;
                width0++;
            end else begin
                seenHigh = 0;
            end
        end
        if (RETRIG)
            checkOutput("req028_retrig_width", 32'(width0 >= 15 && width0 <= 18 && !gap), 32'd1);
        else
            checkOutput("req028_noretrig_width", 32'(width0 >= 9 && width0 <= 12 && !gap), 32'd1);

        // Input held high gives one stretch only.
        width0 = 0;
        for (int k = 0; k < 100; k++) begin
            applyStimulus(2'b01, 1'b1);
            if (outSig[0]) width0++;
        end
        checkOutput("req029_single_stretch", 32'(width0 >= 9 && width0 <= 12), 32'd1);
        checkOutput("req029_low_at_end", 32'(outSig[0]), 32'd0);
        applyStimulus(2'b00, 1'b1);
        for (int k = 0; k < 15; k++) applyStimulus(2'b00, 1'b1);

        // Freeze with ena low; a rise on channel 1 in the window is lost.
        applyStimulus(2'b01, 1'b1);
        applyStimulus(2'b00, 1'b1);
        applyStimulus(2'b00, 1'b1);
        width1 = 0; width0 = 0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus((k == 5) ? 2'b10 : 2'b00, 1'b0);
            if (outSig[0]) width0++;
            if (outSig[1]) width1++;
        end
        checkOutput("req030_frozen_high", 32'(width0), 32'd20);
        checkOutput("req030_ch1_lost", 32'(width1), 32'd0);
        width0 = 0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(2'b00, 1'b1);
            if (outSig[0]) width0++;
        end
        checkOutput("req030_resumes", 32'(width0 >= 1 && width0 <= 9), 32'd1);

        // Reset in the middle of a stretch, input high at release.
        applyStimulus(2'b01, 1'b1);
        for (int k = 0; k < 4; k++) applyStimulus(2'b00, 1'b1);
        inSig = 2'b01;
        doReset();
        applyStimulus(2'b01, 1'b1);
        checkOutput("req031_restart", 32'(outSig[0]), 32'd1);
        for (int k = 0; k < 14; k++) applyStimulus(2'b00, 1'b1);

        // Fast configuration: tick every clock, one-tick hold.
        in2 = 1'b1;
        applyStimulus(2'b00, 1'b1);
        in2 = 1'b0;
        checkOutput("req027_first", 32'(out2), 32'd1);
        checkOutput("req027_busy", 32'(busy2), 32'd1);
        width0 = 1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(2'b00, 1'b1);
            if (out2[0]) width0++;
        end
        checkOutput("req027_width", 32'(width0), 32'd1);

        // Random traffic with slowly toggling inputs and occasional enable drops.
        rv = '0;
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < WIDTH; c++)
                if ($urandom_range(0, 5) == 0) rv[c] = ~rv[c];
            applyStimulus(rv, ($urandom_range(0, 7) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
